// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared encodings and default vectors for the instruction fetch unit.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
    localparam logic [1:0]  PC_SEL_BR  = 2'b01;
    localparam logic [1:0]  PC_SEL_J   = 2'b10;
    localparam logic [1:0]  PC_SEL_JR  = 2'b11;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Combinational candidate next-PC targets for the fetch unit.
// Revision : 1.0  initial release
// ============================================================================
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] id_pc_plus4,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] seq_next,
    output logic [31:0] br_tgt,
    output logic [31:0] jmp_tgt,
    output logic [31:0] jr_tgt
);

    logic [30:0] w_seq_low;
    logic [31:0] w_br_off;

    // The increment stays inside bits 30:0 so the supervisor bit never changes.
    assign w_seq_low = pc[30:0] + 31'd4;
    assign seq_next  = {pc[31], w_seq_low};

    assign w_br_off = {{14{branch_off[15]}}, branch_off, 2'b00};
    assign br_tgt   = id_pc_plus4 + w_br_off;

    assign jmp_tgt  = {id_pc_plus4[31:28], jump_index, 2'b00};

    // User-mode code cannot reach the kernel segment through a register jump.
    assign jr_tgt   = pc[31] ? jr_target : {1'b0, jr_target[30:0]};

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : MIPS fetch front end: PC ownership, redirects, IF/ID register, $k0 write.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IRQ_VEC  = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        k0_we,
    output logic [31:0] k0_data
);

    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        k0_we_q, k0_we_d;
    logic [31:0] k0_data_q, k0_data_d;

    logic [31:0] w_seq_next;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_jr_tgt;
    logic        w_irq_take;

    next_pc_calc u_next_pc_calc (
        .pc          (pc_q),
        .id_pc_plus4 (id_pc_plus4_q),
        .branch_off  (branch_off),
        .jump_index  (jump_index),
        .jr_target   (jr_target),
        .seq_next    (w_seq_next),
        .br_tgt      (w_br_tgt),
        .jmp_tgt     (w_jmp_tgt),
        .jr_tgt      (w_jr_tgt)
    );

    // Interrupts only enter from user mode on a plain sequential fetch.
    assign w_irq_take = irq && !pc_q[31] && !stall && (pc_sel == PC_SEL_SEQ);

    always_comb begin
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        k0_we_d       = 1'b0;
        k0_data_d     = k0_data_q;

        if (exc) begin
            pc_d       = EXC_VEC;
            id_valid_d = 1'b0;
            id_instr_d = NOP_WORD;
            k0_we_d    = 1'b1;
            k0_data_d  = id_pc_plus4_q - 32'd4;
        end else if (w_irq_take) begin
            pc_d       = IRQ_VEC;
            id_valid_d = 1'b0;
            id_instr_d = NOP_WORD;
            k0_we_d    = 1'b1;
            k0_data_d  = pc_q;
        end else if (stall) begin
            if (flush) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_WORD;
            end
        end else if (pc_sel != PC_SEL_SEQ) begin
            case (pc_sel)
                PC_SEL_BR: pc_d = w_br_tgt;
                PC_SEL_J:  pc_d = w_jmp_tgt;
                default:   pc_d = w_jr_tgt;
            endcase
            id_valid_d = 1'b0;
            id_instr_d = NOP_WORD;
        end else begin
            pc_d          = w_seq_next;
            id_instr_d    = rom_data;
            id_pc_plus4_d = w_seq_next;
            id_valid_d    = ~flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_WORD;
            id_pc_plus4_q <= 32'd0;
            k0_we_q       <= 1'b0;
            k0_data_q     <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            k0_we_q       <= k0_we_d;
            k0_data_q     <= k0_data_d;
        end
    end

    assign pc          = pc_q;
    assign rom_addr    = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign k0_we       = k0_we_q;
    assign k0_data     = k0_data_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch front end for the MIPS core.
- Drives the instruction ROM word address and registers the returned word into an IF/ID pipeline register.
- Owns the PC: sequential, branch, jump, jr, interrupt and exception redirects.
- Enforces the PC[31] supervisor bit and produces the $k0 ($26) return-address write for ISR entry.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IRQ_VEC, 32'h8000_0004, interrupt entry (kernel)
EXC_VEC, 32'h8000_0008, exception entry (kernel)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
rom_addr  out  32  instruction address to ROM (= pc, combinational)
rom_data  in  32  instruction word from ROM, combinational same cycle
stall  in  1  hold PC and IF/ID
flush  in  1  load bubble into IF/ID
pc_sel  in  2  00 seq, 01 branch, 10 jump, 11 jr (taken decisions from ID)
branch_off  in  16  branch immediate
jump_index  in  26  J/JAL index field
jr_target  in  32  register value for jr/jalr
irq  in  1  level interrupt request
exc  in  1  exception from ID (undefined instruction)
pc  out  32  current fetch PC
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  IF/ID instruction
id_pc_plus4  out  32  IF/ID PC+4
k0_we  out  1  one-cycle write-enable for $26
k0_data  out  32  return address for $26

Behaviour:
- Reset values: pc=RESET_PC; id_valid=0; id_instr=0; id_pc_plus4=0; k0_we=0; k0_data=0. Reset dominates every other input, including mid-stall and mid-redirect.
- seq_next = {pc[31], pc[30:0]+4}. Bit 31 is never carried into by the increment.
- br_tgt = id_pc_plus4 + (sext(branch_off) << 2), 32-bit wrap.
- jmp_tgt = {id_pc_plus4[31:28], jump_index, 2'b00}.
- jr_tgt = jr_target when pc[31]=1. Otherwise {1'b0, jr_target[30:0]}: user code cannot enter kernel via jr.
- Next-PC priority, evaluated each rising edge:
  1. reset
  2. exc: pc<=EXC_VEC; IF/ID bubble; k0_we<=1; k0_data<=id_pc_plus4-4.
  3. irq accepted only when pc[31]=0, stall=0 and pc_sel=00: pc<=IRQ_VEC; IF/ID bubble; k0_we<=1; k0_data<=pc.
  4. stall: pc held; IF/ID held unless flush=1, in which case IF/ID is a bubble.
  5. pc_sel≠00: pc<=target; IF/ID bubble. No delay slot.
  6. pc_sel=00: pc<=seq_next; id_instr<=rom_data; id_pc_plus4<=seq_next; id_valid<=~flush.
- A rejected irq is not latched. The source holds the level until serviced.
- Bubble means id_valid=0 and id_instr=0; id_pc_plus4 is unchanged.
- k0_we is high for exactly one cycle after acceptance, then returns to 0. k0_data holds its value until the next acceptance.
- Latency: the instruction at address A appears on id_instr one edge after pc=A, with no stall.
- exc and irq asserted together: exc wins; irq is re-evaluated on the next edge (rejected there, since pc[31]=1).
- pc_sel is ignored while stall=1.

Decomposition:
- Package fetch_pkg holds:
  - PC_SEL_SEQ/BR/J/JR encodings
  - NOP word 32'h0
  - default vector constants
- One combinational sub-module, next_pc_calc: computes seq_next, br_tgt, jmp_tgt and jr_tgt (with the supervisor mask).
- The top level owns priority selection and all registers.

Test Plan:
- Reset, ROM word 0x08000003 at address 0 → after edge 1: pc=0x4, id_instr=0x08000003, id_valid=1. Then pc_sel=10, jump_index=3 → pc=0x0000000C, id_valid=0.
- id_pc_plus4=0x000000E4, pc_sel=01, branch_off=0xFFDD → pc=0x00000058, id_valid=0 next cycle.
- pc=0x100, irq=1, pc_sel=00 → pc=0x80000004, k0_we=1 for one cycle, k0_data=0x100. irq held while pc=0x80000010 → no redirect.
- In kernel, pc_sel=11, jr_target=0x00000100 → pc=0x100. In user mode, jr_target=0x80000040 → pc=0x00000040.
- stall for 3 cycles → pc, id_instr and id_valid frozen. stall+flush → id_valid=0, pc unchanged.
- exc and irq together at pc=0x200 with id_pc_plus4=0x200 → pc=0x80000008, k0_data=0x1FC. Reset asserted during stall → next edge pc=0, id_valid=0, k0_we=0.
